regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two requesters, write port, forwarding.
// master = requester/regfile side, slave = arbiter side.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        b_ready;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] pending;
  logic [7:0]  conflict_cnt;
  logic [3:0]  rd_reg1;
  logic [3:0]  rd_reg2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    output rd_reg1, rd_reg2,
    output rf_data1, rf_data2,
    input  a_ready, b_ready,
    input  WriteReg, DstReg, DstData,
    input  pending, conflict_cnt,
    input  fwd_data1, fwd_data2
  );

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    input  rd_reg1, rd_reg2,
    input  rf_data1, rf_data2,
    output a_ready, b_ready,
    output WriteReg, DstReg, DstData,
    output pending, conflict_cnt,
    output fwd_data1, fwd_data2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with one buffer per requester.
// Define WB_BYPASS_EN to forward the write port onto fwd_data1/2.
module regfile_wb_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic        r_a_full;
  logic [3:0]  r_a_reg;
  logic [15:0] r_a_data;
  logic        r_b_full;
  logic [3:0]  r_b_reg;
  logic [15:0] r_b_data;
  logic        r_last;
  logic [7:0]  r_cnt;

  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_a_acc;
  logic        w_b_acc;
  logic        w_both;
  logic        w_wr;
  logic [3:0]  w_dreg;
  logic [15:0] w_ddata;
  logic [15:0] w_pend;

  // r_last: 0 = A served last, 1 = B served last
  assign w_both  = r_a_full & r_b_full;
  assign w_gnt_a = r_a_full & (~r_b_full | r_last);
  assign w_gnt_b = r_b_full & (~r_a_full | ~r_last);

  assign bus.a_ready = ~r_a_full | w_gnt_a;
  assign bus.b_ready = ~r_b_full | w_gnt_b;
  assign w_a_acc = bus.a_valid & bus.a_ready;
  assign w_b_acc = bus.b_valid & bus.b_ready;

  // Write port mux; an R0 entry is consumed without a write strobe
  always_comb begin
    w_wr    = 1'b0;
    w_dreg  = 4'd0;
    w_ddata = 16'd0;
    unique case (1'b1)
      w_gnt_a: begin
        w_wr    = r_a_reg != 4'd0;
        w_dreg  = r_a_reg;
        w_ddata = r_a_data;
      end
      w_gnt_b: begin
        w_wr    = r_b_reg != 4'd0;
        w_dreg  = r_b_reg;
        w_ddata = r_b_data;
      end
      default: ;
    endcase
  end

  assign bus.WriteReg = w_wr;
  assign bus.DstReg   = w_dreg;
  assign bus.DstData  = w_ddata;

  // Mask of registers with a buffered value still waiting
  always_comb begin
    w_pend = 16'd0;
    for (int i = 1; i < 16; i++) begin
      if ((r_a_full && r_a_reg == 4'(i)) ||
          (r_b_full && r_b_reg == 4'(i)))
        w_pend[i] = 1'b1;
    end
  end

  assign bus.pending      = w_pend;
  assign bus.conflict_cnt = r_cnt;

`ifdef WB_BYPASS_EN
  assign bus.fwd_data1 = (w_wr && w_dreg == bus.rd_reg1) ?
                         w_ddata : bus.rf_data1;
  assign bus.fwd_data2 = (w_wr && w_dreg == bus.rd_reg2) ?
                         w_ddata : bus.rf_data2;
`else
  assign bus.fwd_data1 = bus.rf_data1;
  assign bus.fwd_data2 = bus.rf_data2;
`endif

  // Buffer A: refill wins over drain in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_full <= 1'b0;
      r_a_reg  <= 4'd0;
      r_a_data <= 16'd0;
    end else if (w_a_acc) begin
      r_a_full <= 1'b1;
      r_a_reg  <= bus.a_reg;
      r_a_data <= bus.a_data;
    end else if (w_gnt_a) begin
      r_a_full <= 1'b0;
    end
  end

  // Buffer B: refill wins over drain in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_full <= 1'b0;
      r_b_reg  <= 4'd0;
      r_b_data <= 16'd0;
    end else if (w_b_acc) begin
      r_b_full <= 1'b1;
      r_b_reg  <= bus.b_reg;
      r_b_data <= bus.b_data;
    end else if (w_gnt_b) begin
      r_b_full <= 1'b0;
    end
  end

  // Last-served pointer and saturating both-full counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      if (w_gnt_a)
        r_last <= 1'b0;
      else if (w_gnt_b)
        r_last <= 1'b1;
      if (w_both && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter.
// Reference model: per-requester queues plus round-robin rule.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   m_last_b;
  int   m_cnt;
  int   n_err;
  int   n_chk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit gnt_a();
    return qa.size() > 0 && (qb.size() == 0 || m_last_b);
  endfunction

  function automatic bit gnt_b();
    return qb.size() > 0 && (qa.size() == 0 || !m_last_b);
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_last_b = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_outputs();
    bit ga, gb, wr, r0;
    logic [3:0]  dr;
    logic [15:0] dd;
    logic [15:0] pm;
    logic [15:0] f1, f2;
    ga = gnt_a();
    gb = gnt_b();
    dr = 4'd0;
    dd = 16'd0;
    if (ga) begin dr = qa[0].r; dd = qa[0].d; end
    if (gb) begin dr = qb[0].r; dd = qb[0].d; end
    r0 = (ga || gb) && dr == 4'd0;
    wr = (ga || gb) && !r0;
    pm = 16'd0;
    foreach (qa[i]) if (qa[i].r != 4'd0) pm[qa[i].r] = 1'b1;
    foreach (qb[i]) if (qb[i].r != 4'd0) pm[qb[i].r] = 1'b1;
    f1 = bus.rf_data1;
    f2 = bus.rf_data2;
`ifdef WB_BYPASS_EN
    if (wr && dr == bus.rd_reg1) f1 = dd;
    if (wr && dr == bus.rd_reg2) f2 = dd;
`endif
    chk("a_ready", 32'(bus.a_ready), 32'(qa.size() == 0 || ga));
    chk("b_ready", 32'(bus.b_ready), 32'(qb.size() == 0 || gb));
    chk("WriteReg", 32'(bus.WriteReg), 32'(wr));
    chk("DstReg", 32'(bus.DstReg), 32'(dr));
    if (!r0) chk("DstData", 32'(bus.DstData), 32'(dd));
    chk("pending", 32'(bus.pending), 32'(pm));
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));
    chk("fwd_data1", 32'(bus.fwd_data1), 32'(f1));
    chk("fwd_data2", 32'(bus.fwd_data2), 32'(f2));
  endtask

  task automatic model_step();
    bit ga, gb, ra, rb;
    ent_t e;
    ga = gnt_a();
    gb = gnt_b();
    ra = qa.size() == 0 || ga;
    rb = qb.size() == 0 || gb;
    if (qa.size() > 0 && qb.size() > 0 && m_cnt < 255)
      m_cnt++;
    if (ga) begin void'(qa.pop_front()); m_last_b = 1'b0; end
    if (gb) begin void'(qb.pop_front()); m_last_b = 1'b1; end
    if (bus.a_valid && ra) begin
      e.r = bus.a_reg; e.d = bus.a_data; qa.push_back(e);
    end
    if (bus.b_valid && rb) begin
      e.r = bus.b_reg; e.d = bus.b_data; qb.push_back(e);
    end
  endtask

  task automatic cyc_chk();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    cyc_chk();
    cyc_end();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr"}, 32'(bus.WriteReg), 32'd0);
    chk({tag, "_dreg"}, 32'(bus.DstReg), 32'd0);
    chk({tag, "_ddata"}, 32'(bus.DstData), 32'd0);
    chk({tag, "_pend"}, 32'(bus.pending), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.conflict_cnt), 32'd0);
    chk({tag, "_ardy"}, 32'(bus.a_ready), 32'd1);
    chk({tag, "_brdy"}, 32'(bus.b_ready), 32'd1);
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_reg = 4'd0;
    bus.b_reg = 4'd0;
    bus.a_data = 16'd0;
    bus.b_data = 16'd0;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    model_reset();
    idle_inputs();
    bus.rd_reg1 = 4'd0;
    bus.rd_reg2 = 4'd0;
    bus.rf_data1 = 16'd0;
    bus.rf_data2 = 16'd0;
    rst = 1'b1;
    #3;
    chk_reset_outs("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // single write from A
    bus.a_valid = 1'b1;
    bus.a_reg = 4'd3;
    bus.a_data = 16'h1234;
    cycle();
    idle_inputs();
    cyc_chk();
    chk("sw_wr", 32'(bus.WriteReg), 32'd1);
    chk("sw_reg", 32'(bus.DstReg), 32'd3);
    chk("sw_data", 32'(bus.DstData), 32'h1234);
    chk("sw_pend", 32'(bus.pending[3]), 32'd1);
    cyc_end();
    cycle();

    // tie: B wins first since A was served last
    bus.a_valid = 1'b1; bus.a_reg = 4'd1; bus.a_data = 16'hAAAA;
    bus.b_valid = 1'b1; bus.b_reg = 4'd2; bus.b_data = 16'hBBBB;
    cycle();
    idle_inputs();
    cyc_chk();
    chk("tie1_reg", 32'(bus.DstReg), 32'd2);
    chk("tie1_data", 32'(bus.DstData), 32'hBBBB);
    cyc_end();
    cyc_chk();
    chk("tie2_reg", 32'(bus.DstReg), 32'd1);
    chk("tie2_data", 32'(bus.DstData), 32'hAAAA);
    chk("tie_cnt", 32'(bus.conflict_cnt), 32'd1);
    cyc_end();
    cycle();

    // back-to-back streaming on A
    for (int i = 0; i < 4; i++) begin
      bus.a_valid = 1'b1;
      bus.a_reg = 4'(i + 4);
      bus.a_data = 16'(16'h0100 + i);
      cyc_chk();
      chk("str_ardy", 32'(bus.a_ready), 32'd1);
      cyc_end();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cyc_chk();
      if (i == 0) chk("str_wr_last", 32'(bus.WriteReg), 32'd1);
      cyc_end();
    end

    // R0 drop on B
    bus.b_valid = 1'b1;
    bus.b_reg = 4'd0;
    bus.b_data = 16'hFFFF;
    cycle();
    idle_inputs();
    cyc_chk();
    chk("r0_wr", 32'(bus.WriteReg), 32'd0);
    chk("r0_brdy", 32'(bus.b_ready), 32'd1);
    chk("r0_pend", 32'(bus.pending), 32'd0);
    cyc_end();

    // bypass of a write to reg 5
    bus.a_valid = 1'b1;
    bus.a_reg = 4'd5;
    bus.a_data = 16'h0F0F;
    cycle();
    idle_inputs();
    bus.rd_reg1 = 4'd5;
    bus.rf_data1 = 16'h0000;
    cyc_chk();
`ifdef WB_BYPASS_EN
    chk("byp_fwd1", 32'(bus.fwd_data1), 32'h0F0F);
`else
    chk("byp_fwd1", 32'(bus.fwd_data1), 32'h0000);
`endif
    cyc_end();

    // saturation: both held valid for 300 cycles
    for (int i = 0; i < 300; i++) begin
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.a_reg = 4'($urandom_range(1, 15));
      bus.b_reg = 4'($urandom_range(1, 15));
      bus.a_data = 16'($urandom);
      bus.b_data = 16'($urandom);
      cycle();
    end
    cyc_chk();
    chk("sat_cnt", 32'(bus.conflict_cnt), 32'd255);
    cyc_end();
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();

    // reset with both buffers full
    bus.a_valid = 1'b1; bus.a_reg = 4'd7; bus.a_data = 16'h7777;
    bus.b_valid = 1'b1; bus.b_reg = 4'd8; bus.b_data = 16'h8888;
    cycle();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("rstmid");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_chk();
    chk("rstmid_nowr", 32'(bus.WriteReg), 32'd0);
    cyc_end();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.a_valid = ($urandom_range(0, 3) != 0);
      bus.b_valid = ($urandom_range(0, 3) != 0);
      bus.a_reg = 4'($urandom);
      bus.b_reg = 4'($urandom);
      bus.a_data = 16'($urandom);
      bus.b_data = 16'($urandom);
      bus.rd_reg1 = 4'($urandom);
      bus.rd_reg2 = 4'($urandom);
      bus.rf_data1 = 16'($urandom);
      bus.rf_data2 = 16'($urandom);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
